// File: rtl/conv_stream_ctrl.sv
// Upstream controller for the convolution line-buffer chain: accepts a raster
// pixel stream, drives the shift chain and emits KxK window strobes with back-pressure.
module conv_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     sr_ce,
  output logic [WIDTH-1:0]         sr_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic          win_valid_reg;
  logic [CW-1:0] win_col_reg;
  logic [RW-1:0] win_row_reg;
  logic          busy_reg;
  logic          frame_done_reg;

  logic accept;
  logic last_col;
  logic last_row;
  logic win_hit;
  logic win_free;

  // A new pixel may enter only when the window slot is empty or retiring now,
  // so a pending window is never overwritten.
  assign win_free = !win_valid_reg || win_ready;
  assign in_ready = (state_reg == RUN) && win_free;
  assign accept   = in_valid && in_ready;
  assign sr_ce    = accept;
  assign sr_data  = in_data;

  assign last_col = (col_reg == CW'(IMG_W - 1));
  assign last_row = (row_reg == RW'(IMG_H - 1));
  assign win_hit  = (col_reg >= CW'(K - 1)) && (row_reg >= RW'(K - 1));

  assign win_valid  = win_valid_reg;
  assign win_col    = win_col_reg;
  assign win_row    = win_row_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      win_valid_reg  <= 1'b0;
      win_col_reg    <= '0;
      win_row_reg    <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (win_valid_reg && win_ready)
        win_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            col_reg   <= '0;
            row_reg   <= '0;
          end
        end

        RUN: begin
          if (accept) begin
            // Subtraction only under the guard, so coordinates never underflow.
            if (win_hit) begin
              win_valid_reg <= 1'b1;
              win_col_reg   <= col_reg - CW'(K - 1);
              win_row_reg   <= row_reg - RW'(K - 1);
            end
            if (last_col) begin
              col_reg <= '0;
              if (last_row) begin
                row_reg   <= '0;
                state_reg <= DRAIN;
                busy_reg  <= 1'b0;
              end else begin
                row_reg <= row_reg + 1'b1;
              end
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (win_free) begin
            state_reg      <= IDLE;
            frame_done_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Randomized scoreboard bench for conv_stream_ctrl: expected windows are queued per
// frame from the image geometry and checked by an independent monitor.
module tb_conv_stream_ctrl;

  localparam int WIDTH = 8;
  localparam int IW    = 8;
  localparam int IH    = 8;
  localparam int KS    = 3;
  localparam int NPIX  = IW * IH;
  localparam int NWIN  = (IW - KS + 1) * (IH - KS + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             sr_ce;
  logic [WIDTH-1:0] sr_data;
  logic             win_valid;
  logic             win_ready = 1'b0;
  logic [2:0]       win_col;
  logic [2:0]       win_row;
  logic             busy;
  logic             frame_done;

  conv_stream_ctrl #(.WIDTH(WIDTH), .IMG_W(IW), .IMG_H(IH), .K(KS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sr_ce(sr_ce), .sr_data(sr_data),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_col(win_col), .win_row(win_row),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];          // expected window as row*IW+col
  int n_acc = 0;
  int n_win = 0;
  int n_fd = 0;
  int cyc = 0;
  int last_hs = -10;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops on every window handshake.
  initial begin
    bit pend = 0;
    bit hold = 0;
    int pc = 0, pr = 0, hc = 0, hr = 0, got = 0, p = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend = 0;
        hold = 0;
        continue;
      end
      if (pend)
        check("win_latency", {29'd0, win_valid, win_row, win_col} & 32'h7f,
              (1 << 6) | (pr << 3) | pc);
      if (hold)
        check("win_hold", {29'd0, win_valid, win_row, win_col} & 32'h7f,
              (1 << 6) | (hr << 3) | hc);
      pend = 0;
      if (sr_ce) begin
        n_acc++;
        check("sr_data", int'(sr_data), int'(in_data));
        p = int'(sr_data);
        if (p < NPIX && (p % IW) >= KS - 1 && (p / IW) >= KS - 1) begin
          pend = 1;
          pc = (p % IW) - (KS - 1);
          pr = (p / IW) - (KS - 1);
        end
      end
      if (win_valid && win_ready) begin
        n_win++;
        last_hs = cyc;
        got = int'(win_row) * IW + int'(win_col);
        if (exp_q.size() == 0)
          check("win_unexpected", got, -1);
        else
          check("win_coord", got, exp_q.pop_front());
      end
      if (win_valid && !win_ready)
        check("stall_no_shift", int'(sr_ce), 0);
      hold = win_valid && !win_ready;
      hc = int'(win_col);
      hr = int'(win_row);
      if (frame_done) begin
        n_fd++;
        check("frame_done_timing", cyc, last_hs + 1);
        check("frame_done_queue_empty", exp_q.size(), 0);
      end
    end
  end

  task automatic run_frame(input int gap_pct, input int rdy_pct, input bit stall,
                           input bit restart, input int rst_after);
    int idx = 0, n = 0, stall_left = 5, acc0, win0, fd0;
    bit first_seen = 0;
    acc0 = n_acc; win0 = n_win; fd0 = n_fd;
    @(posedge clk); #1;
    // start together with a valid pixel: the pixel must not be taken
    start = 1; in_valid = 1; in_data = 8'hEE; win_ready = 1;
    for (int r = 0; r <= IH - KS; r++)
      for (int c = 0; c <= IW - KS; c++)
        exp_q.push_back(r * IW + c);
    @(negedge clk);
    check("idle_start_no_accept", int'(sr_ce), 0);
    @(posedge clk); #1;
    start = 0;
    check("busy_in_run", int'(busy), 1);
    while (idx < NPIX && n < 3000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = WIDTH'(idx);
      start    = restart && (idx == 20);
      if (stall && win_valid && !first_seen) first_seen = 1;
      if (stall && first_seen && stall_left > 0) begin
        win_ready = 0;
        stall_left--;
      end else begin
        win_ready = ($urandom_range(99) < rdy_pct);
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (rst_after >= 0 && idx > rst_after) break;
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    if (rst_after >= 0) begin
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      check("rst_async_outputs",
            {in_ready, sr_ce, win_valid, busy, frame_done, win_col, win_row}, 0);
      in_valid = 0;
      repeat (4) @(negedge clk);
      check("rst_no_frame_done", n_fd - fd0, 0);
      exp_q.delete();
      @(posedge clk); #3;
      rst_n = 1;
      return;
    end
    check("frame_pixels_sent", idx, NPIX);
    in_valid = 0;
    n = 0;
    while (n_fd == fd0 && n < 60) begin
      @(posedge clk); #1;
      win_ready = 1;
      n++;
    end
    @(negedge clk);
    check("frame_done_seen", n_fd - fd0, 1);
    check("sr_ce_count", n_acc - acc0, NPIX);
    check("window_count", n_win - win0, NWIN);
    check("busy_after_frame", int'(busy), 0);
  endtask

  initial begin
    #1;
    check("reset_outputs",
          {in_ready, sr_ce, win_valid, busy, frame_done, win_col, win_row}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    repeat (2) @(posedge clk);
    run_frame(0, 100, 0, 0, -1);   // continuous stream
    run_frame(0, 100, 1, 0, -1);   // 5-cycle stall on first window
    run_frame(50, 70, 0, 0, -1);   // random gaps and back-pressure
    run_frame(0, 100, 0, 0, 30);   // reset after pixel 30
    run_frame(30, 80, 0, 0, -1);   // fresh frame after reset
    run_frame(0, 100, 0, 1, -1);   // start pulsed during RUN
    run_frame(20, 90, 0, 0, -1);   // back-to-back with previous frame
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
